uart_core_v2: RTL and testbench

Single-clock-domain UART engine that replaces the divided-clock TX/RX pair and handshake synchronisers with clock-enable oversampling.
- Baud rate, frame format and RX flush timeout are set at runtime.
- TX serialises a packed word of up to BYTES_PER_WORD bytes.
- RX packs received bytes into words, flushing early on timeout or error.
- Sits between the peripheral's local TX/RX FIFOs and the pins; config registers drive its config inputs.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_core_v2.sv | 380 ++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_core_v2.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the clock-enable oversampled UART engine.
package uart_pkg;

  typedef enum logic [1:0] {
    ParNone    = 2'd0,
    ParEven    = 2'd1,
    ParOdd     = 2'd2,
    ParNoneAlt = 2'd3
  } parity_t;

  typedef enum logic {
    StopOne = 1'b0,
    StopTwo = 1'b1
  } stop_bits_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_PT  = 8;

  localparam logic [3:0] TICK_LAST   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SAMPLE_TICK = 4'(SAMPLE_PT - 1);

  localparam int unsigned ERR_PAR = 0;
  localparam int unsigned ERR_FRM = 1;
  localparam int unsigned ERR_OVR = 2;

  // Out-of-range data_bits settings fall back to 8-bit frames.
  function automatic logic [3:0] eff_bits(input logic [3:0] d);
    return (d >= 4'd5 && d <= 4'd8) ? d : 4'd8;
  endfunction

  function automatic logic par_en(input parity_t p);
    return (p == ParEven) || (p == ParOdd);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every div+1 clocks, with synchronous clear.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q >= div) && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q >= div)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_core_v2.sv
// UART engine: word-wide TX serialiser and RX byte packer driven by 16x oversample ticks.
module uart_core_v2
  import uart_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = 3,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned TO_W           = 12,
  localparam int unsigned NB_W          = $clog2(BYTES_PER_WORD + 1),
  localparam int unsigned WORD_W        = 8 * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [3:0]        data_bits,
  input  parity_t           parity,
  input  stop_bits_t        stop_bits,
  input  logic [TO_W-1:0]   rx_timeout,
  input  logic [WORD_W-1:0] tx_word,
  input  logic [NB_W-1:0]   tx_nbytes,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  input  logic              rxd,
  output logic [WORD_W-1:0] rx_word,
  output logic [NB_W-1:0]   rx_nbytes,
  output logic [2:0]        rx_err,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              tx_busy,
  output logic              rx_busy
);

  typedef enum logic [2:0] {TxIdle, TxSync, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

  localparam logic [NB_W-1:0] BPW = NB_W'(BYTES_PER_WORD);

  // ---------------- TX ----------------
  tx_state_e         tx_state_q, tx_state_d;
  logic [3:0]        tx_tick_q, tx_tick_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [NB_W-1:0]   tx_left_q, tx_left_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic [WORD_W-1:0] tx_word_q, tx_word_d;
  logic              tx_par_q, tx_par_d;
  logic              tx_stop2_q, tx_stop2_d;
  logic [3:0]        tx_nbits_q, tx_nbits_d;
  parity_t           tx_parity_q, tx_parity_d;
  stop_bits_t        tx_stopb_q, tx_stopb_d;
  logic [DIV_W-1:0]  tx_div_q, tx_div_d, tx_div;
  logic              tx_tick, tx_end;
  logic [NB_W-1:0]   tx_nb_clamp;

  assign tx_div      = (tx_state_q == TxIdle) ? baud_div : tx_div_q;
  assign tx_nb_clamp = (tx_nbytes > BPW) ? BPW : tx_nbytes;
  assign tx_end      = tx_tick && (tx_tick_q == TICK_LAST);

  uart_baud_gen #(.DIV_W(DIV_W)) u_tx_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .div   (tx_div),
    .tick  (tx_tick)
  );

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_tick_d   = tx_tick_q;
    tx_bit_d    = tx_bit_q;
    tx_left_d   = tx_left_q;
    tx_shift_d  = tx_shift_q;
    tx_word_d   = tx_word_q;
    tx_par_d    = tx_par_q;
    tx_stop2_d  = tx_stop2_q;
    tx_nbits_d  = tx_nbits_q;
    tx_parity_d = tx_parity_q;
    tx_stopb_d  = tx_stopb_q;
    tx_div_d    = tx_div_q;
    txd         = 1'b1;
    if (tx_tick && tx_state_q != TxIdle && tx_state_q != TxSync) tx_tick_d = tx_tick_q + 4'd1;
    unique case (tx_state_q)
      TxIdle: begin
        tx_tick_d = '0;
        if (tx_valid && tx_nb_clamp != '0) begin
          tx_word_d   = tx_word;
          tx_left_d   = tx_nb_clamp;
          tx_nbits_d  = eff_bits(data_bits);
          tx_parity_d = parity;
          tx_stopb_d  = stop_bits;
          tx_div_d    = baud_div;
          tx_state_d  = TxSync;
        end
      end
      TxSync: begin
        if (tx_tick) begin
          tx_state_d = TxStart;
          tx_shift_d = tx_word_q[7:0];
          tx_word_d  = tx_word_q >> 8;
          tx_par_d   = 1'b0;
        end
      end
      TxStart: begin
        txd = 1'b0;
        if (tx_end) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
        end
      end
      TxData: begin
        txd = tx_shift_q[0];
        if (tx_end) begin
          tx_par_d   = tx_par_q ^ tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_stop2_d = 1'b0;
          if (tx_bit_q == 3'(tx_nbits_q - 4'd1)) begin
            tx_state_d = par_en(tx_parity_q) ? TxParity : TxStop;
          end
        end
      end
      TxParity: begin
        txd = (tx_parity_q == ParOdd) ? ~tx_par_q : tx_par_q;
        if (tx_end) tx_state_d = TxStop;
      end
      TxStop: begin
        if (tx_end) begin
          if (tx_stopb_q == StopTwo && !tx_stop2_q) begin
            tx_stop2_d = 1'b1;
          end else if (tx_left_q > NB_W'(1)) begin
            tx_left_d  = tx_left_q - 1'b1;
            tx_state_d = TxStart;
            tx_shift_d = tx_word_q[7:0];
            tx_word_d  = tx_word_q >> 8;
            tx_par_d   = 1'b0;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TxIdle;
      tx_tick_q   <= '0;
      tx_bit_q    <= '0;
      tx_left_q   <= '0;
      tx_shift_q  <= '0;
      tx_word_q   <= '0;
      tx_par_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_nbits_q  <= 4'd8;
      tx_parity_q <= ParNone;
      tx_stopb_q  <= StopOne;
      tx_div_q    <= '0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_tick_q   <= tx_tick_d;
      tx_bit_q    <= tx_bit_d;
      tx_left_q   <= tx_left_d;
      tx_shift_q  <= tx_shift_d;
      tx_word_q   <= tx_word_d;
      tx_par_q    <= tx_par_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_nbits_q  <= tx_nbits_d;
      tx_parity_q <= tx_parity_d;
      tx_stopb_q  <= tx_stopb_d;
      tx_div_q    <= tx_div_d;
    end
  end

  assign tx_ready = (tx_state_q == TxIdle);
  assign tx_busy  = (tx_state_q != TxIdle);

  // ---------------- RX ----------------
  rx_state_e         rx_state_q, rx_state_d;
  logic              rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [3:0]        rx_tick_q, rx_tick_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_par_q, rx_par_d;
  logic              rx_perr_q, rx_perr_d;
  logic [3:0]        rx_nbits_q, rx_nbits_d;
  parity_t           rx_parity_q, rx_parity_d;
  logic [DIV_W-1:0]  rx_div_q, rx_div_d, rx_div;
  logic [3:0]        idle_tick_q, idle_tick_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              rx_tick, rx_fall, rx_mid, rx_end, rx_bg_clear;
  logic              byte_done, byte_ferr;

  assign rx_fall     = rxd_s3_q && !rxd_s2_q;
  assign rx_bg_clear = (rx_state_q == RxIdle) && rx_fall;
  assign rx_mid      = rx_tick && (rx_tick_q == SAMPLE_TICK);
  assign rx_end      = rx_tick && (rx_tick_q == TICK_LAST);
  assign rx_div      = (rx_state_q == RxIdle) ? baud_div : rx_div_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_rx_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (rx_bg_clear),
    .div   (rx_div),
    .tick  (rx_tick)
  );

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_byte_d   = rx_byte_q;
    rx_par_d    = rx_par_q;
    rx_perr_d   = rx_perr_q;
    rx_nbits_d  = rx_nbits_q;
    rx_parity_d = rx_parity_q;
    rx_div_d    = rx_div_q;
    idle_tick_d = idle_tick_q;
    idle_cnt_d  = idle_cnt_q;
    byte_done   = 1'b0;
    byte_ferr   = 1'b0;
    if (rx_tick && rx_state_q != RxIdle) rx_tick_d = rx_tick_q + 4'd1;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_fall) begin
          rx_state_d  = RxStart;
          rx_tick_d   = '0;
          rx_nbits_d  = eff_bits(data_bits);
          rx_parity_d = parity;
          rx_div_d    = baud_div;
        end else if (rx_tick) begin
          idle_tick_d = idle_tick_q + 4'd1;
          if (idle_tick_q == TICK_LAST && idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      RxStart: begin
        if (rx_mid && rxd_s2_q) begin
          rx_state_d = RxIdle;
          rx_tick_d  = '0;
        end else if (rx_mid) begin
          idle_tick_d = '0;
          idle_cnt_d  = '0;
        end else if (rx_end) begin
          rx_state_d = RxData;
          rx_bit_d   = '0;
          rx_byte_d  = '0;
          rx_par_d   = 1'b0;
          rx_perr_d  = 1'b0;
        end
      end
      RxData: begin
        if (rx_mid) begin
          rx_byte_d[rx_bit_q] = rxd_s2_q;
          rx_par_d            = rx_par_q ^ rxd_s2_q;
        end
        if (rx_end) begin
          if (rx_bit_q == 3'(rx_nbits_q - 4'd1)) begin
            rx_state_d = par_en(rx_parity_q) ? RxParity : RxStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      RxParity: begin
        if (rx_mid) rx_perr_d = rxd_s2_q != ((rx_parity_q == ParOdd) ? ~rx_par_q : rx_par_q);
        if (rx_end) rx_state_d = RxStop;
      end
      RxStop: begin
        // Leave mid-stop so a start bit during a second stop bit is still caught.
        if (rx_mid) begin
          byte_done   = 1'b1;
          byte_ferr   = !rxd_s2_q;
          rx_state_d  = RxIdle;
          rx_tick_d   = '0;
          idle_tick_d = '0;
          idle_cnt_d  = '0;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // ---------------- Packer and output register ----------------
  logic [WORD_W-1:0] pack_q, pack_d, out_word_q, out_word_d;
  logic [NB_W-1:0]   pack_cnt_q, pack_cnt_d, out_nb_q, out_nb_d;
  logic [2:0]        pack_err_q, pack_err_d, out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout_hit, emit_req, do_emit;

  assign timeout_hit = (rx_timeout != '0) && (idle_cnt_q >= rx_timeout);
  assign emit_req    = (pack_cnt_q != '0) &&
                       ((pack_cnt_q == BPW) || (pack_err_q != 3'b000) || timeout_hit);
  assign do_emit     = emit_req && (!out_valid_q || rx_ready);

  always_comb begin
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    pack_err_d  = pack_err_q;
    out_word_d  = out_word_q;
    out_nb_d    = out_nb_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && rx_ready) out_valid_d = 1'b0;
    if (do_emit) begin
      out_word_d  = pack_q;
      out_nb_d    = pack_cnt_q;
      out_err_d   = pack_err_q;
      out_valid_d = 1'b1;
      pack_d      = '0;
      pack_cnt_d  = '0;
      pack_err_d  = '0;
    end
    if (byte_done) begin
      if (emit_req && !do_emit) begin
        pack_err_d[ERR_OVR] = 1'b1;
      end else begin
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
          if (pack_cnt_d == NB_W'(i)) pack_d[8*i +: 8] = rx_byte_q;
        end
        pack_cnt_d          = pack_cnt_d + 1'b1;
        pack_err_d[ERR_FRM] = pack_err_d[ERR_FRM] | byte_ferr;
        pack_err_d[ERR_PAR] = pack_err_d[ERR_PAR] | rx_perr_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q    <= 1'b1;
      rxd_s2_q    <= 1'b1;
      rxd_s3_q    <= 1'b1;
      rx_state_q  <= RxIdle;
      rx_tick_q   <= '0;
      rx_bit_q    <= '0;
      rx_byte_q   <= '0;
      rx_par_q    <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_nbits_q  <= 4'd8;
      rx_parity_q <= ParNone;
      rx_div_q    <= '0;
      idle_tick_q <= '0;
      idle_cnt_q  <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      pack_err_q  <= '0;
      out_word_q  <= '0;
      out_nb_q    <= '0;
      out_err_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rxd_s1_q    <= rxd;
      rxd_s2_q    <= rxd_s1_q;
      rxd_s3_q    <= rxd_s2_q;
      rx_state_q  <= rx_state_d;
      rx_tick_q   <= rx_tick_d;
      rx_bit_q    <= rx_bit_d;
      rx_byte_q   <= rx_byte_d;
      rx_par_q    <= rx_par_d;
      rx_perr_q   <= rx_perr_d;
      rx_nbits_q  <= rx_nbits_d;
      rx_parity_q <= rx_parity_d;
      rx_div_q    <= rx_div_d;
      idle_tick_q <= idle_tick_d;
      idle_cnt_q  <= idle_cnt_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_err_q  <= pack_err_d;
      out_word_q  <= out_word_d;
      out_nb_q    <= out_nb_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rx_word   = out_word_q;
  assign rx_nbytes = out_nb_q;
  assign rx_err    = out_err_q;
  assign rx_valid  = out_valid_q;
  assign rx_busy   = (rx_state_q != RxIdle);

endmodule

// File: tb/tb_uart_core_v2.sv
// Directed bench for uart_core_v2: TX framing/timing, loopback packing, timeout, errors, overrun.
module tb_uart_core_v2;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;  // baud_div=3 -> 4 clk per tick, 16 ticks per bit

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  parity_t     parity;
  stop_bits_t  stop_bits;
  logic [11:0] rx_timeout;
  logic [23:0] tx_word;
  logic [1:0]  tx_nbytes;
  logic        tx_valid, tx_ready, txd, rxd, rx_valid, rx_ready, tx_busy, rx_busy;
  logic [23:0] rx_word;
  logic [1:0]  rx_nbytes;
  logic [2:0]  rx_err;
  logic        rxd_drv, loopback;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;
  assign rxd = loopback ? txd : rxd_drv;

  uart_core_v2 dut (
    .clk        (clk),
    .rst        (rst),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity     (parity),
    .stop_bits  (stop_bits),
    .rx_timeout (rx_timeout),
    .tx_word    (tx_word),
    .tx_nbytes  (tx_nbytes),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .rxd        (rxd),
    .rx_word    (rx_word),
    .rx_nbytes  (rx_nbytes),
    .rx_err     (rx_err),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_busy    (tx_busy),
    .rx_busy    (rx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input int nb, input parity_t par,
                         input bit bad_par, input bit stop_low);
    logic p;
    p = 1'b0;
    rxd_drv = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rxd_drv = b[i];
      p       = p ^ b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (par == ParEven || par == ParOdd) begin
      rxd_drv = ((par == ParOdd) ? ~p : p) ^ bad_par;
      repeat (BIT_CLK) @(negedge clk);
    end
    rxd_drv = ~stop_low;
    repeat (BIT_CLK) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  task automatic wait_rx(input string tag, input int maxc);
    int n;
    n = 0;
    while (!rx_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rx_valid, 1'b1);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] bits;
    logic [23:0] exp_w;
    logic [7:0]  v;
    bit          low_seen;
    int          n;

    rst        = 1'b1;
    baud_div   = 16'd3;
    data_bits  = 4'd8;
    parity     = ParNone;
    stop_bits  = StopOne;
    rx_timeout = '0;
    tx_word    = '0;
    tx_nbytes  = '0;
    tx_valid   = 1'b0;
    rx_ready   = 1'b0;
    rxd_drv    = 1'b1;
    loopback   = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_txd", txd, 1'b1);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_word", rx_word, 24'h0);
    chk("rst_rx_nbytes", rx_nbytes, 2'd0);
    chk("rst_rx_err", rx_err, 3'b000);
    chk("rst_busy", {tx_busy, rx_busy}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // TX 8N1, three bytes
    exp_w     = 24'h3C_A5_55;
    tx_word   = exp_w;
    tx_nbytes = 2'd3;
    tx_valid  = 1'b1;
    chk("tx_ready_idle", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_drop", tx_ready, 1'b0);
    chk("tx_busy_set", tx_busy, 1'b1);
    n = 0;
    while (txd && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", txd, 1'b0);
    repeat (BIT_CLK / 2) @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      bits[k] = txd;
      if (k < 29) repeat (BIT_CLK) @(negedge clk);
    end
    n = 0;
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_ready_low_clks", 32'(1888 + n), 32'd1920);
    chk("tx_frame_bits", {bits[29], bits[20], bits[19], bits[10], bits[9], bits[0]}, 6'b101010);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) v[i] = bits[10*b + 1 + i];
      chk($sformatf("tx_byte%0d", b), v, exp_w[8*b +: 8]);
    end

    // tx_nbytes = 0: accepted, nothing sent
    tx_word   = 24'hFF_FF_00;
    tx_nbytes = 2'd0;
    tx_valid  = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_zero_ready", {tx_ready, tx_busy}, 2'b10);
    low_seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (!txd) low_seen = 1'b1;
    end
    chk("tx_zero_quiet", low_seen, 1'b0);

    // Loopback 7E2, bit 7 of the first and last bytes must be stripped
    loopback  = 1'b1;
    data_bits = 4'd7;
    parity    = ParEven;
    stop_bits = StopTwo;
    tx_word   = 24'hC1_41_C1;
    tx_nbytes = 2'd3;
    tx_valid  = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_rx("loop_valid", 3000);
    chk("loop_word", rx_word, 24'h41_41_41);
    chk("loop_nbytes", rx_nbytes, 2'd3);
    chk("loop_err", rx_err, 3'b000);
    pulse_ready();
    chk("loop_consumed", rx_valid, 1'b0);
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    loopback  = 1'b0;
    data_bits = 4'd8;
    parity    = ParNone;
    stop_bits = StopOne;
    do_reset();

    // Timeout flush of a single byte after 4 idle bit periods
    rx_timeout = 12'd4;
    send_rx(8'h12, 8, ParNone, 1'b0, 1'b0);
    n = 0;
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency_window", (640 + n >= 860) && (640 + n <= 876), 1'b1);
    chk("to_word", rx_word, 24'h00_00_12);
    chk("to_nbytes", rx_nbytes, 2'd1);
    chk("to_err", rx_err, 3'b000);
    pulse_ready();
    rx_timeout = '0;
    do_reset();

    // 8O1 with a parity error on byte 2 forces an early emit
    parity = ParOdd;
    send_rx(8'h5A, 8, ParOdd, 1'b0, 1'b0);
    send_rx(8'h33, 8, ParOdd, 1'b1, 1'b0);
    wait_rx("par_valid", 200);
    chk("par_word", rx_word, 24'h00_33_5A);
    chk("par_nbytes", rx_nbytes, 2'd2);
    chk("par_err", rx_err, 3'b001);
    pulse_ready();
    send_rx(8'hC3, 8, ParOdd, 1'b0, 1'b0);
    repeat (600) @(negedge clk);
    chk("no_flush_timeout0", rx_valid, 1'b0);
    parity = ParNone;
    do_reset();

    // Framing error: stop bit held low
    send_rx(8'h7F, 8, ParNone, 1'b0, 1'b1);
    wait_rx("frm_valid", 200);
    chk("frm_word", rx_word, 24'h00_00_7F);
    chk("frm_nbytes", rx_nbytes, 2'd1);
    chk("frm_err", rx_err, 3'b010);
    pulse_ready();
    do_reset();

    // 4-clk glitch is rejected as a false start
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (4) @(negedge clk);
    chk("glitch_busy", rx_busy, 1'b1);
    repeat (80) @(negedge clk);
    chk("glitch_idle", rx_busy, 1'b0);
    chk("glitch_no_byte", rx_valid, 1'b0);
    do_reset();

    // Overrun: 7 bytes with consumer stalled
    for (int i = 1; i <= 7; i++) send_rx(8'(8'h11 * i), 8, ParNone, 1'b0, 1'b0);
    wait_rx("ovr_valid1", 100);
    chk("ovr_word1", rx_word, 24'h33_22_11);
    chk("ovr_err1", rx_err, 3'b000);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid2", rx_valid, 1'b1);
    chk("ovr_word2", rx_word, 24'h66_55_44);
    chk("ovr_nbytes2", rx_nbytes, 2'd3);
    chk("ovr_err2", rx_err, 3'b100);
    @(negedge clk);
    rx_ready = 1'b0;
    chk("ovr_drained", rx_valid, 1'b0);
    do_reset();

    // Asynchronous reset mid-frame drives txd high without a clock edge
    tx_word   = 24'h00_00_00;
    tx_nbytes = 2'd1;
    tx_valid  = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n = 0;
    while (txd && n < 200) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1'b1);
    chk("async_rst_busy", tx_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
